// File: rtl/disp_pkg.sv
// Shared display definitions: anode vector type, anode encodings and the
// select-to-anode decode used by the dual seven-segment display path.
// Encodings are stored in active-low form; polarity is applied by the
// helper functions so callers never hand-invert constants.
package disp_pkg;

    localparam int ANODE_W = 2;

    typedef logic [ANODE_W-1:0] anode_t;

    // Active-low reference encodings: bit 0 = display 1, bit 1 = display 2.
    localparam anode_t OFF_AL = 2'b11;
    localparam anode_t ON1_AL = 2'b10;
    localparam anode_t ON2_AL = 2'b01;

    function automatic anode_t polar(input anode_t code, input bit active_low);
        return active_low ? code : ~code;
    endfunction

    function automatic anode_t off_code(input bit active_low);
        return polar(OFF_AL, active_low);
    endfunction

    // select = 1 lights display 1, select = 0 lights display 2.
    function automatic anode_t decode(input logic sel, input bit active_low);
        return polar(sel ? ON1_AL : ON2_AL, active_low);
    endfunction

endpackage

// File: rtl/blank_timer.sv
// Loadable down-counter that times the anode dead-time window.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset, clears the count
//   load   in   load value into the counter this edge
//   value  in   count to load
//   busy   out  count is non-zero (blanking still in progress)
module blank_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/demux_2_1.sv
// Registered 1-to-2 anode demultiplexer for the dual seven-segment display.
// Converts the display-select bit into one-hot anode enables and forces both
// anodes off for BLANK_CYCLES cycles after every select change so the old
// digit's segments never ghost onto the new one.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   en         in   display enable; 0 forces both anodes off
//   select     in   1 = display 1, 0 = display 2 (already in clk domain)
//   anode_out  out  [0] = display 1, [1] = display 2, registered
module demux_2_1
    import disp_pkg::*;
#(
    parameter int BLANK_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   select,
    output anode_t anode_out
);

    localparam int CNT_RAW = $clog2(BLANK_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    // The change edge itself is the first OFF cycle, so the timer only
    // has to cover the remaining BLANK_CYCLES-1 cycles.
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam anode_t OFF = off_code(ACTIVE_LOW);

    logic sel_q;
    logic change;
    logic load;
    logic busy;

    assign change = (select != sel_q);
    assign load   = change && (BLANK_CYCLES > 0);

    blank_timer #(.CNT_W(CNT_W)) u_blank_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (LOAD_VAL),
        .busy  (busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q     <= 1'b0;
            anode_out <= OFF;
        end else if (change) begin
            // Every change, including a revert during blanking, restarts
            // the dead-time window in full.
            sel_q <= select;
            if (BLANK_CYCLES == 0)
                anode_out <= en ? decode(select, ACTIVE_LOW) : OFF;
            else
                anode_out <= OFF;
        end else if (busy) begin
            anode_out <= OFF;
        end else begin
            anode_out <= en ? decode(sel_q, ACTIVE_LOW) : OFF;
        end
    end

endmodule

// File: tb/tb_demux_2_1.sv
module tb_demux_2_1;

    logic       clk;
    logic       reset;
    logic       en;
    logic       select;
    logic [1:0] anode_out;

    int checks;
    int errors;

    demux_2_1 #(.BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .select    (select),
        .anode_out (anode_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge; drives and checks
    // both happen here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        select = 1'b0;
        en     = 1'b1;
        repeat (3) tick();
        checks++;
        if (anode_out !== 2'b11) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", anode_out, 2'b11);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (anode_out !== 2'b01) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", anode_out, 2'b01);
        end
        tick();
        checks++;
        if (anode_out !== 2'b01) begin
            errors++;
            $display("FAIL reset_steady got=%b exp=%b", anode_out, 2'b01);
        end
    endtask

    task automatic test_change();
        logic [1:0] exp [4] = '{2'b11, 2'b11, 2'b10, 2'b10};
        select = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (anode_out !== exp[i]) begin
                errors++;
                $display("FAIL change_0to1[%0d] got=%b exp=%b", i, anode_out, exp[i]);
            end
        end
    endtask

    task automatic test_revert();
        logic [1:0] exp [4] = '{2'b11, 2'b11, 2'b11, 2'b01};
        select = 1'b0;
        repeat (3) tick();
        checks++;
        if (anode_out !== 2'b01) begin
            errors++;
            $display("FAIL revert_setup got=%b exp=%b", anode_out, 2'b01);
        end
        select = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) select = 1'b0;  // revert one cycle into blanking
            checks++;
            if (anode_out !== exp[i]) begin
                errors++;
                $display("FAIL revert[%0d] got=%b exp=%b", i, anode_out, exp[i]);
            end
        end
    endtask

    task automatic test_en();
        select = 1'b1;
        repeat (3) tick();
        checks++;
        if (anode_out !== 2'b10) begin
            errors++;
            $display("FAIL en_setup got=%b exp=%b", anode_out, 2'b10);
        end
        en = 1'b0;
        tick();
        checks++;
        if (anode_out !== 2'b11) begin
            errors++;
            $display("FAIL en_off got=%b exp=%b", anode_out, 2'b11);
        end
        en = 1'b1;
        tick();
        checks++;
        if (anode_out !== 2'b10) begin
            errors++;
            $display("FAIL en_on got=%b exp=%b", anode_out, 2'b10);
        end
    endtask

    task automatic test_en_mid_blank();
        logic [1:0] exp [4] = '{2'b11, 2'b11, 2'b11, 2'b01};
        select = 1'b0;
        en     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) en = 1'b1;  // counter has already expired here
            checks++;
            if (anode_out !== exp[i]) begin
                errors++;
                $display("FAIL en_mid_blank[%0d] got=%b exp=%b", i, anode_out, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        // Async reset while a display is lit: must go OFF without an edge.
        #2 reset = 1'b0;
        #1;
        checks++;
        if (anode_out !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_on got=%b exp=%b", anode_out, 2'b11);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (anode_out !== 2'b01) begin
            errors++;
            $display("FAIL async_reset_on_rel got=%b exp=%b", anode_out, 2'b01);
        end
        // Reset mid-blank: counter must clear, so select=0 shows ON2 at once.
        select = 1'b1;
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (anode_out !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_blank got=%b exp=%b", anode_out, 2'b11);
        end
        select = 1'b0;
        tick();
        checks++;
        if (anode_out !== 2'b11) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", anode_out, 2'b11);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (anode_out !== 2'b01) begin
            errors++;
            $display("FAIL reset_blank_cleared got=%b exp=%b", anode_out, 2'b01);
        end
        // Out of reset with select=1: sel_q is 0, so a full blank applies.
        reset = 1'b0;
        select = 1'b1;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] e;
            tick();
            e = (i < 2) ? 2'b11 : 2'b10;
            checks++;
            if (anode_out !== e) begin
                errors++;
                $display("FAIL reset_sel1[%0d] got=%b exp=%b", i, anode_out, e);
            end
        end
    endtask

    // Windowed reference: the output lights only when select has held the
    // same value for the current and two previous samples and en is high.
    task automatic test_random();
        logic       p1, p2;
        logic [1:0] exp, last_on;
        int         off_run;
        reset  = 1'b0;
        select = 1'b0;
        en     = 1'b1;
        tick();
        reset   = 1'b1;
        p1      = 1'b0;
        p2      = 1'b0;
        off_run = 2;
        last_on = 2'b11;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) select = ~select;
            en = ($urandom_range(7) != 0);
            tick();
            exp = (en && select == p1 && p1 == p2) ? (select ? 2'b10 : 2'b01) : 2'b11;
            p2 = p1;
            p1 = select;
            checks++;
            if (anode_out !== exp) begin
                errors++;
                $display("FAIL random[%0d] got=%b exp=%b", i, anode_out, exp);
            end
            if (anode_out === 2'b00) begin
                errors++;
                $display("FAIL both_on[%0d] got=%b", i, anode_out);
            end
            if (anode_out === 2'b11) begin
                off_run++;
            end else begin
                if (anode_out !== last_on && last_on !== 2'b11) begin
                    checks++;
                    if (off_run < 2) begin
                        errors++;
                        $display("FAIL dead_time[%0d] off_run=%0d exp>=2", i, off_run);
                    end
                end
                last_on = anode_out;
                off_run = 0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        en     = 1'b1;
        select = 1'b0;
        test_reset();
        test_change();
        test_revert();
        test_en();
        test_en_mid_blank();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
